// File: rtl/arb4_sched.sv
// Four-requester round-robin scheduler for one shared single-user resource.
// Each ownership is capped at MAXHOLD cycles and followed by a GAP-cycle recovery window.
module arb4_sched #(
  parameter int unsigned MAXHOLD = 8,
  parameter int unsigned GAP     = 1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] Req,
  input  logic [3:0] Release,
  output logic [3:0] Gnt,
  output logic [1:0] GntId,
  output logic       Busy,
  output logic       Timeout
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] HOLD  = 2'b01;
  localparam logic [1:0] CLEAR = 2'b10;

  localparam logic [7:0] MAXHOLD_C = 8'(MAXHOLD);
  localparam logic [3:0] GAP_C     = 4'(GAP);

  logic [1:0] state_reg, state_next;
  logic [7:0] hold_cnt_reg, hold_cnt_next;
  logic [3:0] gap_cnt_reg, gap_cnt_next;
  logic [1:0] ptr_reg, ptr_next;
  logic [3:0] gnt_reg, gnt_next;
  logic [1:0] gnt_id_reg, gnt_id_next;
  logic       busy_reg, busy_next;
  logic       timeout_reg, timeout_next;

  logic [1:0] cand_idx [4];
  logic [3:0] cand_hit;
  logic [1:0] pick_idx;
  logic       owner_rel;
  logic       hold_expired;
  logic       gap_done;

  // Candidate gi is the master gi+1 positions after the last owner.
  for (genvar gi = 0; gi < 4; gi++) begin : g_cand
    assign cand_idx[gi] = ptr_reg + 2'(gi + 1);
    assign cand_hit[gi] = Req[cand_idx[gi]];
  end

  always_comb begin
    pick_idx = cand_idx[3];
    for (int k = 2; k >= 0; k--) begin
      if (cand_hit[k]) pick_idx = cand_idx[k];
    end
  end

  assign owner_rel    = Release[gnt_id_reg] | ~Req[gnt_id_reg];
  assign hold_expired = (hold_cnt_reg == MAXHOLD_C);
  assign gap_done     = (gap_cnt_reg == GAP_C);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg    <= IDLE;
      hold_cnt_reg <= '0;
      gap_cnt_reg  <= '0;
      ptr_reg      <= 2'd3;
      gnt_reg      <= '0;
      gnt_id_reg   <= '0;
      busy_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
      ptr_reg      <= ptr_next;
      gnt_reg      <= gnt_next;
      gnt_id_reg   <= gnt_id_next;
      busy_reg     <= busy_next;
      timeout_reg  <= timeout_next;
    end
  end

  // The unused code 2'b11 falls into the default arm and behaves as IDLE.
  always_comb begin
    state_next = IDLE;
    case (state_reg)
      HOLD:    state_next = (owner_rel || hold_expired) ? CLEAR : HOLD;
      CLEAR:   state_next = gap_done ? IDLE : CLEAR;
      default: state_next = (|Req) ? HOLD : IDLE;
    endcase
  end

  always_comb begin
    hold_cnt_next = hold_cnt_reg;
    gap_cnt_next  = gap_cnt_reg;
    ptr_next      = ptr_reg;
    gnt_next      = gnt_reg;
    gnt_id_next   = gnt_id_reg;
    busy_next     = busy_reg;
    timeout_next  = timeout_reg;
    case (state_reg)
      HOLD: begin
        // A release on the expiry edge wins, so no Timeout pulse in that case.
        if (owner_rel) begin
          gnt_next     = '0;
          gap_cnt_next = 4'd1;
        end else if (hold_expired) begin
          gnt_next     = '0;
          timeout_next = 1'b1;
          gap_cnt_next = 4'd1;
        end else begin
          hold_cnt_next = hold_cnt_reg + 8'd1;
        end
      end
      CLEAR: begin
        timeout_next = 1'b0;
        if (gap_done) begin
          busy_next = 1'b0;
        end else begin
          gap_cnt_next = gap_cnt_reg + 4'd1;
        end
      end
      default: begin
        if (|Req) begin
          gnt_next      = 4'b0001 << pick_idx;
          gnt_id_next   = pick_idx;
          ptr_next      = pick_idx;
          busy_next     = 1'b1;
          hold_cnt_next = 8'd1;
        end
      end
    endcase
  end

  assign Gnt     = gnt_reg;
  assign GntId   = gnt_id_reg;
  assign Busy    = busy_reg;
  assign Timeout = timeout_reg;

endmodule

// File: tb/tb_arb4_sched.sv
// Self-checking bench for arb4_sched: directed vector table, reset corners,
// and a randomized run against an ownership-level reference model.
module tb_arb4_sched;

  localparam int MAXHOLD = 8;
  localparam int GAP     = 1;
  localparam int BOUND   = 3 * (MAXHOLD + GAP + 1);

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [3:0] Req = '0;
  logic [3:0] Release = '0;
  logic [3:0] Gnt;
  logic [1:0] GntId;
  logic       Busy;
  logic       Timeout;

  arb4_sched #(.MAXHOLD(MAXHOLD), .GAP(GAP)) dut (
    .Clock(Clock), .Reset(Reset), .Req(Req), .Release(Release),
    .Gnt(Gnt), .GntId(GntId), .Busy(Busy), .Timeout(Timeout)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [3:0] req;
    logic [3:0] rel;
    int         reps;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t tbl[$];
  int n_pass = 0;
  int n_total = 0;

  function automatic vec_t mk(logic [3:0] rq, logic [3:0] rl, int n,
                              logic [3:0] g, logic [1:0] id, logic b, logic t);
    vec_t v;
    v.req = rq; v.rel = rl; v.reps = n; v.gnt = g; v.id = id; v.busy = b; v.to = t;
    return v;
  endfunction

  function automatic logic [7:0] outs();
    return {Gnt, GntId, Busy, Timeout};
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got gnt=%b id=%0d busy=%b to=%b, required gnt=%b id=%0d busy=%b to=%b",
                  nm, act[7:4], act[3:2], act[1], act[0], exp[7:4], exp[3:2], exp[1], exp[0]);
  endtask

  task automatic step(input logic [3:0] rq, input logic [3:0] rl);
    Req = rq;
    Release = rl;
    @(posedge Clock);
    #1;
  endtask

  // Reference model state: ownership expressed as owner index / cycles held / recovery left.
  int m_owner, m_held, m_recover, m_ptr, m_id;
  logic m_to;
  logic [3:0] rq, rl;
  int wait_cnt [4];
  int max_wait, onehot_bad, lost, ob;

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    // Directed sequence starting from reset, MAXHOLD=8 and GAP=1.
    tbl.push_back(mk(4'b1111, 4'b0000, 2, 4'b0001, 2'd0, 1, 0));
    tbl.push_back(mk(4'b1111, 4'b0001, 1, 4'b0000, 2'd0, 1, 0));
    tbl.push_back(mk(4'b1111, 4'b0000, 1, 4'b0000, 2'd0, 0, 0));
    tbl.push_back(mk(4'b1111, 4'b0000, 2, 4'b0010, 2'd1, 1, 0));
    tbl.push_back(mk(4'b1111, 4'b0010, 1, 4'b0000, 2'd1, 1, 0));
    tbl.push_back(mk(4'b1111, 4'b0000, 1, 4'b0000, 2'd1, 0, 0));
    tbl.push_back(mk(4'b1111, 4'b0000, 2, 4'b0100, 2'd2, 1, 0));
    tbl.push_back(mk(4'b1111, 4'b0100, 1, 4'b0000, 2'd2, 1, 0));
    tbl.push_back(mk(4'b1111, 4'b0000, 1, 4'b0000, 2'd2, 0, 0));
    tbl.push_back(mk(4'b1111, 4'b0000, 2, 4'b1000, 2'd3, 1, 0));
    tbl.push_back(mk(4'b1111, 4'b1000, 1, 4'b0000, 2'd3, 1, 0));
    tbl.push_back(mk(4'b1111, 4'b0000, 1, 4'b0000, 2'd3, 0, 0));
    tbl.push_back(mk(4'b1111, 4'b0000, 1, 4'b0001, 2'd0, 1, 0));
    tbl.push_back(mk(4'b1111, 4'b1110, 1, 4'b0001, 2'd0, 1, 0));
    tbl.push_back(mk(4'b1110, 4'b0000, 1, 4'b0000, 2'd0, 1, 0));
    tbl.push_back(mk(4'b1110, 4'b0000, 1, 4'b0000, 2'd0, 0, 0));
    tbl.push_back(mk(4'b1110, 4'b0000, 3, 4'b0010, 2'd1, 1, 0));
    tbl.push_back(mk(4'b1100, 4'b0000, 1, 4'b0000, 2'd1, 1, 0));
    tbl.push_back(mk(4'b0000, 4'b0000, 2, 4'b0000, 2'd1, 0, 0));
    tbl.push_back(mk(4'b0100, 4'b0000, 8, 4'b0100, 2'd2, 1, 0));
    tbl.push_back(mk(4'b0100, 4'b0000, 1, 4'b0000, 2'd2, 1, 1));
    tbl.push_back(mk(4'b0100, 4'b0000, 1, 4'b0000, 2'd2, 0, 0));
    tbl.push_back(mk(4'b0100, 4'b0000, 8, 4'b0100, 2'd2, 1, 0));
    tbl.push_back(mk(4'b0100, 4'b0100, 1, 4'b0000, 2'd2, 1, 0));
    tbl.push_back(mk(4'b0000, 4'b0000, 1, 4'b0000, 2'd2, 0, 0));
    tbl.push_back(mk(4'b1000, 4'b0000, 2, 4'b1000, 2'd3, 1, 0));

    // Asynchronous reset asserted mid-cycle, away from any clock edge.
    @(posedge Clock);
    #3 Reset = 1'b1;
    #1 chk("reset_async", outs(), 8'h00);
    @(posedge Clock);
    #4 Reset = 1'b0;
    #1 chk("reset_release", outs(), 8'h00);

    for (int v = 0; v < tbl.size(); v++) begin
      for (int r = 0; r < tbl[v].reps; r++) begin
        step(tbl[v].req, tbl[v].rel);
        $display("vec %0d.%0d req=%b rel=%b -> gnt=%b id=%0d busy=%b to=%b",
                 v, r, tbl[v].req, tbl[v].rel, Gnt, GntId, Busy, Timeout);
        chk($sformatf("vec%0d.%0d", v, r), outs(),
            {tbl[v].gnt, tbl[v].id, tbl[v].busy, tbl[v].to});
      end
    end

    // Reset while master 3 owns: grant drops at once, next grant restarts at master 0.
    #3 Reset = 1'b1;
    #1 chk("reset_mid_hold", outs(), 8'h00);
    Req = 4'b1111;
    @(posedge Clock);
    #1 chk("reset_held_edge", outs(), 8'h00);
    #3 Reset = 1'b0;
    step(4'b1111, 4'b0000);
    $display("post-reset grant gnt=%b id=%0d busy=%b", Gnt, GntId, Busy);
    chk("post_reset_grant", outs(), {4'b0001, 2'd0, 1'b1, 1'b0});

    // Randomized run against the reference model.
    #3 Reset = 1'b1;
    Req = '0;
    Release = '0;
    #2 Reset = 1'b0;
    m_owner = -1; m_held = 0; m_recover = 0; m_ptr = 3; m_id = 0; m_to = 1'b0;
    rq = '0; lost = -1; max_wait = 0; onehot_bad = 0;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;

    for (int c = 0; c < 10000; c++) begin
      rl = '0;
      for (int i = 0; i < 4; i++) begin
        if (m_owner == i) begin
          rq[i] = ($urandom_range(7) != 0);
          rl[i] = ($urandom_range(5) == 0);
        end else begin
          if (lost == i) rq[i] = 1'b0;
          else if (!rq[i]) rq[i] = ($urandom_range(2) == 0);
          rl[i] = ($urandom_range(7) == 0);
        end
      end
      Req = rq;
      Release = rl;
      @(posedge Clock);

      ob = m_owner;
      m_to = 1'b0;
      if (m_owner >= 0) begin
        if (rl[m_owner] || !rq[m_owner]) begin
          m_owner = -1; m_recover = GAP;
        end else if (m_held == MAXHOLD) begin
          m_owner = -1; m_recover = GAP; m_to = 1'b1;
        end else begin
          m_held++;
        end
      end else if (m_recover > 0) begin
        m_recover--;
      end else if (rq != 4'b0000) begin
        for (int k = 1; k <= 4; k++) begin
          if (m_owner < 0 && rq[(m_ptr + k) % 4]) begin
            m_owner = (m_ptr + k) % 4;
            m_held = 1;
            m_id = m_owner;
          end
        end
        m_ptr = m_id;
      end
      lost = (ob >= 0 && m_owner != ob) ? ob : -1;

      for (int i = 0; i < 4; i++) begin
        if (rq[i] && ob != i && m_owner != i) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end

      #1;
      if ($countones(Gnt) > 1) onehot_bad++;
      chk($sformatf("rand%0d", c), outs(),
          {(m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000, 2'(m_id),
           (m_owner >= 0 || m_recover > 0), m_to});
    end

    n_total++;
    if (onehot_bad == 0) n_pass++;
    else $display("FAIL onehot: got %0d non-one-hot cycles, required 0", onehot_bad);
    n_total++;
    if (max_wait <= BOUND) n_pass++;
    else $display("FAIL max_wait: got %0d cycles, required at most %0d", max_wait, BOUND);
    $display("random run: longest wait %0d cycles (bound %0d)", max_wait, BOUND);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/arb4_sched.md
# arb4_sched

Four-requester round-robin scheduler that shares one single-user resource, such as the `fsm` controller and its A/F/G datapath, between up to four independent masters. It grants exclusive ownership to one requester at a time. A hold timeout stops any owner from monopolising the resource, and a programmable recovery gap lets the resource settle back to its idle state before the next owner is granted. The block sits between the requesting masters and the shared resource's input mux, and drives the mux select.

## Interface
- MAXHOLD, default 8: maximum consecutive grant cycles per ownership; legal range 1..255.
- GAP, default 1: recovery cycles after each release before returning to idle; legal range 1..15.
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- Req  in  4  request per master; level, held until granted and finished.
- Release  in  4  per-master release strobe; only the current owner's bit is honoured.
- Gnt  out  4  one-hot grant, registered; all zero when nobody owns.
- GntId  out  2  index of the current or last owner; drives the resource mux select.
- Busy  out  1  high from the grant edge until recovery completes.
- Timeout  out  1  one-cycle pulse when an owner is forcibly released.

## Operation
- Reset, applied asynchronously at any time including mid-grant, forces these values immediately:
  - Gnt=0, GntId=0, Busy=0, Timeout=0.
  - state=IDLE, hold counter=0, gap counter=0.
  - round-robin pointer ptr=3, so master 0 has first priority.
- The FSM has states IDLE, HOLD, CLEAR, encoded in 2 bits; code 2'b11 is unused and decodes to IDLE.
- IDLE:
  - Req==0: stay in IDLE.
  - Otherwise select the first set Req bit, searching (ptr+1), (ptr+2), (ptr+3), (ptr+4) mod 4.
  - On the same edge: Gnt[i]<=1, GntId<=i, ptr<=i, Busy<=1, hold counter<=1, state<=HOLD.
- HOLD, where i=GntId:
  - Priority 1: if Release[i]=1 or Req[i]=0, then Gnt<=0 and state<=CLEAR, with gap counter<=1 (voluntary release).
  - Priority 2: else if hold counter==MAXHOLD, then Gnt<=0, Timeout<=1, state<=CLEAR, gap counter<=1.
  - Otherwise the hold counter increments.
  - Release bits and Req changes of non-owners are ignored.
- CLEAR:
  - Timeout<=0 on the first CLEAR edge.
  - If gap counter==GAP: state<=IDLE and Busy<=0.
  - Otherwise the gap counter increments.
  - No grant is issued from CLEAR. GntId holds the last owner.
- A timed-out owner is not blacklisted. It re-enters normal rotation and, with ptr already past it, is served after the other pending requesters.
- Simultaneous Release and timeout on the same edge counts as voluntary: no Timeout pulse.
- Req of the owner deasserting and Release asserting together counts as a single release.
- Gnt is always one-hot or zero. No two bits are ever set, including across reset release.

## Timing
- Grant latency: Req sampled at edge e in IDLE gives Gnt high after edge e, i.e. 1 cycle.
- Maximum ownership: Gnt stays high for exactly MAXHOLD cycles if never released.
- Release latency: Release sampled at edge d gives Gnt low after edge d.
- Idle spacing after release: Gnt low for GAP+1 cycles before the next grant (GAP cycles in CLEAR plus 1 in IDLE).
- Busy falls at edge d+GAP and is low for at least 1 cycle between ownerships.
- Timeout is high exactly 1 cycle, coincident with the first cycle Gnt is low.
- Worst-case wait for any continuously requesting master: 3*(MAXHOLD+GAP+1) cycles.

## Test plan
- Reset and first grant:
  - Stimulus: assert Reset mid-cycle; release it; hold Req=4'b1111 at the next edge.
  - Required: all outputs 0 while Reset is asserted, independent of Clock.
  - Required: after the next edge, Gnt=4'b0001, GntId=0, Busy=1.
- Round-robin rotation:
  - Stimulus: Req=4'b1111 held, each owner pulses Release 2 cycles after its grant, GAP=1.
  - Required: grant order 0,1,2,3,0.
  - Required: each grant lasts 2 cycles, with 2 idle cycles between grants.
- Timeout:
  - Stimulus: MAXHOLD=8, Req=4'b0100 held, no Release.
  - Required: Gnt=4'b0100 for exactly 8 cycles, then a 1-cycle Timeout pulse.
  - Required: regrant to master 2 after GAP+1 low cycles.
- Release/timeout collision and non-owner release:
  - Stimulus: Release[owner] asserted on the MAXHOLD-th edge.
  - Required: no Timeout pulse.
  - Stimulus: Release[other] asserted during HOLD.
  - Required: no effect.
- Owner drops Req and reset mid-HOLD:
  - Stimulus: Req[1] deasserts at cycle 3 of ownership.
  - Required: Gnt low after that edge.
  - Stimulus: Reset asserted in HOLD with Gnt=4'b1000.
  - Required: Gnt=0 immediately; the next grant after reset goes to master 0.
- Fairness stress:
  - Stimulus: random Req/Release for 10k cycles.
  - Required: Gnt always one-hot or zero.
  - Required: no master waits more than 3*(MAXHOLD+GAP+1) cycles.
  - Required: Busy is 0 whenever state is IDLE.
